mem_access_sequencer: RTL and testbench

- Sequences and arbitrates the single shared port of the unified instruction/data block RAM in the multicycle CPU.
- Two requesters share the port: instruction fetch (IF) and load/store (LS).
- Performs region decode: instruction words sit at [0, INSTR_WORDS); data words sit at [INSTR_WORDS, 2^ADDR_W).
- Handles BRAM read latency and returns one registered response per access.

---
 rtl/mem_access_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates instruction fetch and load/store onto one shared BRAM port,
// with region decode, read-latency handling and one registered response per access.
// Optional MEM_PERF_CNT_EN adds saturating per-class access counters.
module mem_access_sequencer #(
   parameter int INSTR_WORDS = 80,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int RD_LATENCY  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_fault,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_fault,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]       perf_if_cnt,
   output logic [31:0]       perf_ld_cnt,
   output logic [31:0]       perf_st_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [ADDR_W-1:0] IW   = ADDR_W'(INSTR_WORDS);
   localparam logic [1:0]        LAST = 2'(RD_LATENCY - 1);
   state_t     state;
   logic [1:0] cnt;
   logic [1:0] streak;
   logic       sel_ls, sel_we, sel_fault;
   logic       if_oob, ls_sfault, starve, pick_ls;
   assign if_oob    = if_addr >= IW;
   assign ls_sfault = ls_we && ls_addr < IW;
   assign starve    = streak == 2'd2 && if_req;
   assign pick_ls   = ls_req && !starve;
   // sequencer FSM: arbitrate in IDLE, drive the BRAM in ISSUE, wait out read latency, respond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         streak    <= '0;
         sel_ls    <= 1'b0;
         sel_we    <= 1'b0;
         sel_fault <= 1'b0;
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         if_fault  <= 1'b0;
         ls_gnt    <= 1'b0;
         ls_rvalid <= 1'b0;
         ls_rdata  <= '0;
         ls_fault  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         if_gnt    <= 1'b0;
         ls_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         if_fault  <= 1'b0;
         ls_fault  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         case (state)
            IDLE: if (ls_req || if_req) begin
               state     <= ISSUE;
               busy      <= 1'b1;
               sel_ls    <= pick_ls;
               sel_we    <= pick_ls && ls_we;
               sel_fault <= pick_ls ? ls_sfault : if_oob;
               ls_gnt    <= pick_ls;
               if_gnt    <= !pick_ls;
               mem_en    <= pick_ls || !if_oob;
               mem_we    <= pick_ls && ls_we && !ls_sfault;
               mem_addr  <= pick_ls ? ls_addr : if_addr;
               mem_wdata <= (pick_ls && ls_we) ? ls_wdata : '0;
               streak    <= (pick_ls && if_req) ? streak + 2'd1 : 2'd0;
            end
            ISSUE: begin
               state     <= sel_we ? RESP : WAIT;
               mem_en    <= sel_we ? 1'b0 : mem_en;
               ls_rvalid <= sel_we;
               ls_fault  <= sel_we && sel_fault;
            end
            WAIT: if (cnt == LAST) begin
               state     <= RESP;
               cnt       <= '0;
               mem_en    <= 1'b0;
               if_rvalid <= !sel_ls;
               if_fault  <= !sel_ls && sel_fault;
               if_rdata  <= sel_ls ? if_rdata : (sel_fault ? '0 : mem_rdata);
               ls_rvalid <= sel_ls;
               ls_rdata  <= sel_ls ? mem_rdata : ls_rdata;
            end else begin
               cnt <= cnt + 2'd1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
`ifdef MEM_PERF_CNT_EN
   // count every completed access, faulted ones included, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_if_cnt <= '0;
         perf_ld_cnt <= '0;
         perf_st_cnt <= '0;
      end else if (state == RESP) begin
         if (!sel_ls && perf_if_cnt != '1) perf_if_cnt <= perf_if_cnt + 32'd1;
         if (sel_ls && !sel_we && perf_ld_cnt != '1) perf_ld_cnt <= perf_ld_cnt + 32'd1;
         if (sel_ls && sel_we && perf_st_cnt != '1) perf_st_cnt <= perf_st_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: directed checks of the shared-port sequencer against a 1-cycle BRAM model.
module tb_mem_access_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [9:0]  if_addr = '0;
   logic        if_gnt, if_rvalid, if_fault;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [9:0]  ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_gnt, ls_rvalid, ls_fault;
   logic [31:0] ls_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        busy;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] perf_if_cnt, perf_ld_cnt, perf_st_cnt;
`endif
   logic [31:0] mem [0:1023];
   int checks = 0;
   int errors = 0;

   mem_access_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_fault(if_fault),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_PERF_CNT_EN
      , .perf_if_cnt(perf_if_cnt), .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt)
`endif
   );

   always #5 clk = ~clk;

   // read-first BRAM with one cycle of read latency
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= mem[mem_addr];
         if (mem_we) mem[mem_addr] = mem_wdata;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [114:0] all_outs;
      return {if_gnt, if_rvalid, if_rdata, if_fault, ls_gnt, ls_rvalid, ls_rdata, ls_fault,
              mem_en, mem_we, mem_addr, mem_wdata, busy};
   endfunction

   task automatic test_reset;
      repeat (2) tick;
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL reset_outs: got %h expected 0", all_outs());
      end
      rst_n = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_reset_mid_wait;
      logic seen = 1'b0;
      if_addr = 10'd5;
      if_req = 1'b1;
      tick;
      if_req = 1'b0;
      checks++;
      if ({if_gnt, mem_en, mem_addr} !== {1'b1, 1'b1, 10'd5}) begin
         errors++;
         $display("FAIL rstwait_issue: gnt/en/addr=%b/%b/%0d expected 1/1/5", if_gnt, mem_en, mem_addr);
      end
      tick;
      checks++;
      if ({busy, mem_en, if_rvalid} !== 3'b110) begin
         errors++;
         $display("FAIL rstwait_wait: busy/en/rvalid=%b%b%b expected 110", busy, mem_en, if_rvalid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL rstwait_outs: got %h expected 0", all_outs());
      end
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (if_rvalid || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL rstwait_norvalid: stray rvalid/busy=%b expected 0", seen);
      end
   endtask

   task automatic test_if_read;
      if_addr = 10'd3;
      if_req = 1'b1;
      tick;
      if_req = 1'b0;
      checks++;
      if ({if_gnt, ls_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 10'd3}) begin
         errors++;
         $display("FAIL ifrd_issue: gnt/lsgnt/en/we/addr=%b%b%b%b/%0d expected 1010/3",
                  if_gnt, ls_gnt, mem_en, mem_we, mem_addr);
      end
      tick;
      checks++;
      if (if_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL ifrd_early: if_rvalid=%b expected 0 at t+1", if_rvalid);
      end
      tick;
      checks++;
      if ({if_rvalid, if_fault, if_rdata} !== {2'b10, 32'h00A00093}) begin
         errors++;
         $display("FAIL ifrd_resp: rvalid/fault/rdata=%b/%b/%h expected 1/0/00a00093",
                  if_rvalid, if_fault, if_rdata);
      end
      tick;
      checks++;
      if ({if_rvalid, busy, if_rdata} !== {2'b00, 32'h00A00093}) begin
         errors++;
         $display("FAIL ifrd_hold: rvalid/busy/rdata=%b/%b/%h expected 0/0/00a00093",
                  if_rvalid, busy, if_rdata);
      end
   endtask

   task automatic test_store_load;
      ls_addr = 10'd85;
      ls_wdata = 32'hDEADBEEF;
      ls_we = 1'b1;
      ls_req = 1'b1;
      tick;
      ls_req = 1'b0;
      checks++;
      if ({ls_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd85, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL st_issue: gnt/en/we/addr/wdata=%b%b%b/%0d/%h expected 111/85/deadbeef",
                  ls_gnt, mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick;
      checks++;
      if ({ls_rvalid, ls_fault, ls_rdata, mem[85]} !== {2'b10, 32'h0, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL st_resp: rvalid/fault/rdata/mem85=%b/%b/%h/%h expected 1/0/0/deadbeef",
                  ls_rvalid, ls_fault, ls_rdata, mem[85]);
      end
      tick;
      ls_we = 1'b0;
      ls_wdata = '0;
      ls_req = 1'b1;
      tick;
      ls_req = 1'b0;
      checks++;
      if ({ls_gnt, mem_en, mem_we} !== 3'b110) begin
         errors++;
         $display("FAIL ld_issue: gnt/en/we=%b%b%b expected 110", ls_gnt, mem_en, mem_we);
      end
      tick;
      tick;
      checks++;
      if ({ls_rvalid, ls_fault, ls_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL ld_resp: rvalid/fault/rdata=%b/%b/%h expected 1/0/deadbeef",
                  ls_rvalid, ls_fault, ls_rdata);
      end
      tick;
   endtask

   task automatic test_store_fault;
      ls_addr = 10'd10;
      ls_wdata = 32'hCAFEF00D;
      ls_we = 1'b1;
      ls_req = 1'b1;
      tick;
      ls_req = 1'b0;
      checks++;
      if ({ls_gnt, mem_we} !== 2'b10) begin
         errors++;
         $display("FAIL stf_issue: gnt/mem_we=%b%b expected 10", ls_gnt, mem_we);
      end
      tick;
      ls_we = 1'b0;
      checks++;
      if ({ls_rvalid, ls_fault, ls_rdata, mem[10]} !== {2'b11, 32'hDEADBEEF, 32'h12345678}) begin
         errors++;
         $display("FAIL stf_resp: rvalid/fault/rdata/mem10=%b/%b/%h/%h expected 1/1/deadbeef/12345678",
                  ls_rvalid, ls_fault, ls_rdata, mem[10]);
      end
      tick;
   endtask

   task automatic test_if_fault;
`ifdef MEM_PERF_CNT_EN
      logic [31:0] before = perf_if_cnt;
`endif
      if_addr = 10'd90;
      if_req = 1'b1;
      tick;
      if_req = 1'b0;
      checks++;
      if ({if_gnt, mem_en} !== 2'b10) begin
         errors++;
         $display("FAIL iff_issue: gnt/mem_en=%b%b expected 10", if_gnt, mem_en);
      end
      tick;
      tick;
      checks++;
      if ({if_rvalid, if_fault, if_rdata} !== {2'b11, 32'h0}) begin
         errors++;
         $display("FAIL iff_resp: rvalid/fault/rdata=%b/%b/%h expected 1/1/0", if_rvalid, if_fault, if_rdata);
      end
      tick;
`ifdef MEM_PERF_CNT_EN
      checks++;
      if (perf_if_cnt !== before + 32'd1) begin
         errors++;
         $display("FAIL iff_perf: perf_if_cnt=%0d expected %0d", perf_if_cnt, before + 32'd1);
      end
`endif
   endtask

   task automatic test_arbitration;
      logic [5:0] exp_ls = 6'b011011;
      int n = 0;
      int last = 0;
      int cyc = 0;
      if_addr = 10'd4;
      ls_addr = 10'd85;
      ls_we = 1'b0;
      if_req = 1'b1;
      ls_req = 1'b1;
      while (n < 6 && cyc < 80) begin
         tick;
         cyc++;
         if (if_gnt || ls_gnt) begin
            checks++;
            if (ls_gnt !== exp_ls[n] || if_gnt === ls_gnt) begin
               errors++;
               $display("FAIL arb_order grant %0d: ls_gnt=%b if_gnt=%b expected ls_gnt=%b if_gnt=%b",
                        n, ls_gnt, if_gnt, exp_ls[n], !exp_ls[n]);
            end
            if (n > 0) begin
               checks++;
               if (cyc - last != 4) begin
                  errors++;
                  $display("FAIL arb_spacing grant %0d: gap=%0d expected 4", n, cyc - last);
               end
            end
            last = cyc;
            n++;
         end
      end
      if_req = 1'b0;
      ls_req = 1'b0;
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL arb_timeout: grants=%0d expected 6", n);
      end
      cyc = 0;
      while (busy && cyc < 20) begin
         tick;
         cyc++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL arb_drain: busy=%b expected 0", busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[3] = 32'h00A00093;
      mem[4] = 32'h00000013;
      mem[10] = 32'h12345678;
      test_reset;
      test_reset_mid_wait;
      test_if_read;
      test_store_load;
      test_store_fault;
      test_if_fault;
      test_arbitration;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
